// File: rtl/hamming_decoder_8bit_pipe.sv
// (12,8) Hamming SEC decoder with a 2-stage valid/ready pipeline and
// saturating statistics counters for corrected and uncorrectable words.
module hamming_decoder_8bit_pipe #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [11:0]      code_in,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [7:0]       data_out,
    output logic [3:0]       syndrome_out,
    output logic             err_corr,
    output logic             err_uncorr,
    input  logic             cnt_clr,
    output logic [CNT_W-1:0] corr_cnt,
    output logic [CNT_W-1:0] uncorr_cnt
);

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    function automatic logic [3:0] calc_syndrome(input logic [11:0] code);
        logic [7:0] d;
        logic [3:0] q;
        d    = code[11:4];
        q[0] = d[0] ^ d[1] ^ d[3] ^ d[4] ^ d[6];
        q[1] = d[0] ^ d[2] ^ d[3] ^ d[5] ^ d[6];
        q[2] = d[1] ^ d[2] ^ d[3] ^ d[7];
        q[3] = d[4] ^ d[5] ^ d[6] ^ d[7];
        return q ^ code[3:0];
    endfunction

    // Syndromes with two or more bits set (and below 13) point at one data bit.
    function automatic logic [7:0] flip_mask(input logic [3:0] s);
        logic [7:0] m;
        case (s)
            4'd3:    m = 8'h01;
            4'd5:    m = 8'h02;
            4'd6:    m = 8'h04;
            4'd7:    m = 8'h08;
            4'd9:    m = 8'h10;
            4'd10:   m = 8'h20;
            4'd11:   m = 8'h40;
            4'd12:   m = 8'h80;
            default: m = 8'h00;
        endcase
        return m;
    endfunction

    logic             s1_valid_r;
    logic [7:0]       s1_data_r;
    logic [3:0]       s1_syn_r;
    logic             s2_valid_r;
    logic [7:0]       data_r;
    logic [3:0]       syn_r;
    logic             corr_r;
    logic             uncorr_r;
    logic [CNT_W-1:0] corr_cnt_r;
    logic [CNT_W-1:0] uncorr_cnt_r;

    logic             adv2_s;
    logic             in_ready_s;
    logic             deliver_s;
    logic [3:0]       syn_in_s;
    logic [7:0]       dec_data_s;
    logic             dec_corr_s;
    logic             dec_uncorr_s;

    assign adv2_s     = !s2_valid_r || out_ready;
    assign in_ready_s = !s1_valid_r || adv2_s;
    assign deliver_s  = s2_valid_r && out_ready;
    assign syn_in_s   = calc_syndrome(code_in);

    // Decode stage-1 contents into corrected data and error flags.
    always_comb begin
        dec_data_s   = s1_data_r;
        dec_corr_s   = 1'b0;
        dec_uncorr_s = 1'b0;
        case (s1_syn_r)
            4'd0: begin
                dec_corr_s   = 1'b0;
                dec_uncorr_s = 1'b0;
            end
            4'd1, 4'd2, 4'd4, 4'd8: begin
                dec_corr_s = 1'b1;
            end
            4'd13, 4'd14, 4'd15: begin
                dec_uncorr_s = 1'b1;
            end
            default: begin
                dec_corr_s = 1'b1;
                dec_data_s = s1_data_r ^ flip_mask(s1_syn_r);
            end
        endcase
    end

    // Stage 1: capture received data and its syndrome on accept.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid_r <= 1'b0;
            s1_data_r  <= 8'h00;
            s1_syn_r   <= 4'h0;
        end else if (in_ready_s) begin
            s1_valid_r <= in_valid;
            if (in_valid) begin
                s1_data_r <= code_in[11:4];
                s1_syn_r  <= syn_in_s;
            end
        end
    end

    // Stage 2: output register; fields hold while the consumer stalls.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s2_valid_r <= 1'b0;
            data_r     <= 8'h00;
            syn_r      <= 4'h0;
            corr_r     <= 1'b0;
            uncorr_r   <= 1'b0;
        end else if (adv2_s) begin
            s2_valid_r <= s1_valid_r;
            if (s1_valid_r) begin
                data_r   <= dec_data_s;
                syn_r    <= s1_syn_r;
                corr_r   <= dec_corr_s;
                uncorr_r <= dec_uncorr_s;
            end
        end
    end

    // Saturating statistics; a clear wins over a same-cycle delivery.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            corr_cnt_r   <= {CNT_W{1'b0}};
            uncorr_cnt_r <= {CNT_W{1'b0}};
        end else if (cnt_clr) begin
            corr_cnt_r   <= {CNT_W{1'b0}};
            uncorr_cnt_r <= {CNT_W{1'b0}};
        end else begin
            if (deliver_s && corr_r && (corr_cnt_r != CNT_MAX)) begin
                corr_cnt_r <= corr_cnt_r + CNT_ONE;
            end
            if (deliver_s && uncorr_r && (uncorr_cnt_r != CNT_MAX)) begin
                uncorr_cnt_r <= uncorr_cnt_r + CNT_ONE;
            end
        end
    end

    assign in_ready     = in_ready_s;
    assign out_valid    = s2_valid_r;
    assign data_out     = data_r;
    assign syndrome_out = syn_r;
    assign err_corr     = corr_r;
    assign err_uncorr   = uncorr_r;
    assign corr_cnt     = corr_cnt_r;
    assign uncorr_cnt   = uncorr_cnt_r;

endmodule

// File: tb/tb_hamming_decoder_8bit_pipe.sv
// Scoreboard bench for hamming_decoder_8bit_pipe: directed codewords with
// hand-computed results, backpressure, counter saturation/clear and reset.
module tb_hamming_decoder_8bit_pipe;

    localparam int CNT_W = 2;

    logic             clk;
    logic             rst_n;
    logic             in_valid;
    logic             in_ready;
    logic [11:0]      code_in;
    logic             out_valid;
    logic             out_ready;
    logic [7:0]       data_out;
    logic [3:0]       syndrome_out;
    logic             err_corr;
    logic             err_uncorr;
    logic             cnt_clr;
    logic [CNT_W-1:0] corr_cnt;
    logic [CNT_W-1:0] uncorr_cnt;

    hamming_decoder_8bit_pipe #(.CNT_W(CNT_W)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .code_in(code_in), .out_valid(out_valid), .out_ready(out_ready),
        .data_out(data_out), .syndrome_out(syndrome_out), .err_corr(err_corr),
        .err_uncorr(err_uncorr), .cnt_clr(cnt_clr), .corr_cnt(corr_cnt),
        .uncorr_cnt(uncorr_cnt)
    );

    typedef struct packed {
        logic [7:0] d;
        logic [3:0] s;
        logic       c;
        logic       u;
    } exp_t;

    exp_t       sb_q[$];
    int         total = 0;
    int         bad = 0;
    logic [1:0] m_corr = 2'd0;
    logic [1:0] m_uncorr = 2'd0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Drive one word; expectation is queued once the DUT is seen ready.
    task automatic send(input logic [11:0] code, input logic [7:0] ed, input logic [3:0] es,
                        input logic ec, input logic eu);
        int waited;
        exp_t e;
        in_valid = 1'b1;
        code_in  = code;
        waited   = 0;
        @(negedge clk);
        while (!in_ready && waited < 50) begin
            waited++;
            @(negedge clk);
        end
        if (!in_ready) begin
            check("accept_timeout", 32'(in_ready), 32'd1);
        end else begin
            e.d = ed; e.s = es; e.c = ec; e.u = eu;
            sb_q.push_back(e);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        in_valid = 1'b0;
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Monitor: compare delivered words and track the counter model.
    always @(negedge clk) begin
        exp_t e;
        if (!rst_n) begin
            m_corr   = 2'd0;
            m_uncorr = 2'd0;
        end else begin
            check("corr_cnt", 32'(corr_cnt), 32'(m_corr));
            check("uncorr_cnt", 32'(uncorr_cnt), 32'(m_uncorr));
            if (out_valid && out_ready) begin
                if (sb_q.size() == 0) begin
                    check("unexpected_word", 32'({data_out, syndrome_out}), 32'hFFFF_FFFF);
                end else begin
                    e = sb_q.pop_front();
                    check("out_word", 32'({data_out, syndrome_out, err_corr, err_uncorr}), 32'(e));
                end
            end
            if (cnt_clr) begin
                m_corr   = 2'd0;
                m_uncorr = 2'd0;
            end else begin
                if (out_valid && out_ready && err_corr && m_corr != 2'd3) m_corr = m_corr + 2'd1;
                if (out_valid && out_ready && err_uncorr && m_uncorr != 2'd3) m_uncorr = m_uncorr + 2'd1;
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat;
        rst_n = 1'b0; in_valid = 1'b0; code_in = 12'h000; out_ready = 1'b1; cnt_clr = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_fields", 32'({data_out, syndrome_out, err_corr, err_uncorr}), 32'd0);
        check("rst_cnts", 32'({corr_cnt, uncorr_cnt}), 32'd0);
        check("rst_in_ready", 32'(in_ready), 32'd1);
        @(posedge clk); #1;
        rst_n = 1'b1;

        // Latency of a clean word
        send(12'hA53, 8'hA5, 4'd0, 1'b0, 1'b0);
        in_valid = 1'b0;
        lat = 0;
        while (lat < 10) begin
            lat++;
            @(negedge clk);
            if (out_valid) break;
        end
        check("latency", 32'(lat), 32'd2);
        idle(2);

        // Back-to-back: clean, data error, parity error, uncorrectable
        send(12'hA53, 8'hA5, 4'd0,  1'b0, 1'b0);
        send(12'hAD3, 8'hA5, 4'd7,  1'b1, 1'b0);
        send(12'hA57, 8'hA5, 4'd4,  1'b1, 1'b0);
        send(12'hA5E, 8'hA5, 4'd13, 1'b0, 1'b1);
        send(12'hFF3, 8'hFF, 4'd0,  1'b0, 1'b0);
        idle(4);
        check("cnt_after_basic", 32'({corr_cnt, uncorr_cnt}), 32'({2'd2, 2'd1}));

        // Backpressure: two words fill the pipe, third waits at the source
        out_ready = 1'b0;
        send(12'h000, 8'h00, 4'd0, 1'b0, 1'b0);
        send(12'hA53, 8'hA5, 4'd0, 1'b0, 1'b0);
        @(negedge clk);
        check("full_in_ready", 32'(in_ready), 32'd0);
        check("full_out_valid", 32'(out_valid), 32'd1);
        fork
            send(12'hAD3, 8'hA5, 4'd7, 1'b1, 1'b0);
            begin
                repeat (3) @(posedge clk);
                #1 out_ready = 1'b1;
            end
        join
        idle(4);
        check("bp_drained", 32'(sb_q.size()), 32'd0);

        // Saturation at 3 after a clear
        @(posedge clk); #1 cnt_clr = 1'b1;
        @(posedge clk); #1 cnt_clr = 1'b0;
        check("clr_cnts", 32'({corr_cnt, uncorr_cnt}), 32'd0);
        send(12'h253, 8'hA5, 4'd12, 1'b1, 1'b0);
        send(12'hA43, 8'hA5, 4'd3,  1'b1, 1'b0);
        send(12'hA52, 8'hA5, 4'd1,  1'b1, 1'b0);
        send(12'hA51, 8'hA5, 4'd2,  1'b1, 1'b0);
        send(12'hA5B, 8'hA5, 4'd8,  1'b1, 1'b0);
        send(12'hA5C, 8'hA5, 4'd15, 1'b0, 1'b1);
        send(12'hA5D, 8'hA5, 4'd14, 1'b0, 1'b1);
        idle(4);
        check("corr_sat", 32'(corr_cnt), 32'd3);
        check("uncorr_val", 32'(uncorr_cnt), 32'd2);

        // Clear coincident with a corrected delivery
        out_ready = 1'b0;
        send(12'hAD3, 8'hA5, 4'd7, 1'b1, 1'b0);
        idle(3);
        out_ready = 1'b1;
        cnt_clr   = 1'b1;
        @(posedge clk); #1 cnt_clr = 1'b0;
        check("clr_wins", 32'(corr_cnt), 32'd0);
        idle(2);

        // Asynchronous reset mid-stream
        send(12'hA53, 8'hA5, 4'd0, 1'b0, 1'b0);
        send(12'hAD3, 8'hA5, 4'd7, 1'b1, 1'b0);
        in_valid = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        check("mid_rst_valid", 32'(out_valid), 32'd0);
        check("mid_rst_fields", 32'({data_out, syndrome_out, err_corr, err_uncorr}), 32'd0);
        check("mid_rst_cnts", 32'({corr_cnt, uncorr_cnt}), 32'd0);
        sb_q.delete();
        @(posedge clk); #1 rst_n = 1'b1;
        send(12'hA57, 8'hA5, 4'd4, 1'b1, 1'b0);
        idle(5);
        check("final_drain", 32'(sb_q.size()), 32'd0);
        check("final_corr", 32'(corr_cnt), 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/hamming_decoder_8bit_pipe.md
Name: hamming_decoder_8bit_pipe

Overview:
Downstream stage of the (12,8) Hamming encoder. Accepts the 12-bit codeword {data[7:0], parity[3:0]} after storage or transmission, computes the syndrome and corrects any single-bit error. Delivers the 8-bit data with error flags through a 2-stage valid/ready pipeline and keeps saturating error-statistics counters.

Parameters:
CNT_W, 16, width of each error-statistics counter

Ports:
clk  in  1  clock, all state on rising edge
rst_n  in  1  asynchronous active-low reset
in_valid  in  1  code_in valid
in_ready  out  1  block accepts code_in this cycle
code_in  in  12  [11:4]=data, [3:0]=parity
out_valid  out  1  output word valid
out_ready  in  1  consumer accepts output word
data_out  out  8  corrected data
syndrome_out  out  4  syndrome of this word
err_corr  out  1  single error corrected (data or parity bit)
err_uncorr  out  1  syndrome not mappable; data passed raw
cnt_clr  in  1  synchronous clear of both counters
corr_cnt  out  CNT_W  count of delivered words with err_corr
uncorr_cnt  out  CNT_W  count of delivered words with err_uncorr

Behaviour:
- Reset (rst_n=0, asynchronous): s1_valid=0, s2_valid=0, out_valid=0, data_out=0, syndrome_out=0, err_corr=0, err_uncorr=0, corr_cnt=0, uncorr_cnt=0. In-flight words are discarded.
- Recomputed parity from received data d=code_in[11:4]:
  - q0=d0^d1^d3^d4^d6
  - q1=d0^d2^d3^d5^d6
  - q2=d1^d2^d3^d7
  - q3=d4^d5^d6^d7
  - syndrome s = q ^ code_in[3:0].
- Stage 1 registers code_in and s when in_valid && in_ready.
- Stage 2 registers the decode result from stage 1.
- Syndrome map:
  - s=0: no error; flags 0.
  - s=1,2,4,8: parity bit error; err_corr=1; data unchanged.
  - s=3,5,6,7,9,10,11,12: flip d0,d1,d2,d3,d4,d5,d6,d7 respectively; err_corr=1.
  - s=13,14,15: err_uncorr=1; err_corr=0; data_out = raw d.
- Handshake:
  - adv2 = !s2_valid || out_ready.
  - in_ready = !s1_valid || adv2 (combinational; no dependency on in_valid).
  - Stage 1 moves to stage 2 when s1_valid && adv2.
  - out_valid = s2_valid. Output fields hold stable while out_valid && !out_ready.
- Latency: 2 cycles from accepted input to out_valid with out_ready held high. Throughput is 1 word/cycle.
- Full: both stages valid and out_ready=0 gives in_ready=0. No word is lost or duplicated.
- Simultaneous accept and deliver in the same cycle is legal at every stage.
- Counters:
  - Increment on out_valid && out_ready, per flag.
  - Saturate at 2^CNT_W-1; no wrap.
  - cnt_clr has priority over a same-cycle increment: counter goes to 0 and that event is not counted.
- Double errors may miscorrect or alias to s=0 (SEC code only). This is expected behaviour, not a bug.

Test Plan:
- Clean word: code_in=0xA53, out_ready=1 -> 2 cycles later data_out=0xA5, syndrome_out=0, flags 0.
- Data error: 0xAD3 (d3 flipped) -> data_out=0xA5, syndrome_out=7, err_corr=1, corr_cnt=1.
- Parity error: 0xA57 -> data_out=0xA5, syndrome_out=4, err_corr=1.
- Uncorrectable: 0xA5E -> syndrome_out=13, err_uncorr=1, data_out=0xA5, uncorr_cnt increments.
- Backpressure: stream 0x000,0xA53,0xAD3 with out_ready=0 for 5 cycles -> in_ready drops after 2 accepted, third word held by the source. On release, 3 words emerge in order with no loss or duplication.
- Counters: CNT_W=2, send 5 corrected words -> corr_cnt saturates at 3. Assert cnt_clr coincident with a corrected delivery -> corr_cnt=0. Assert rst_n low mid-stream -> all outputs 0 immediately.
